axis_sample_pacer: RTL and testbench
====================================

# axis_sample_pacer

Upstream feeder for the biquad filter chain. Accepts bursty 16-bit samples on an AXI4-Stream slave (DMA/BRAM playback or capture bridge) and buffers them in a small FIFO. Releases one sample to the filter's AXI4-Stream slave every `clk_div` clocks, which gives a fixed sample rate (default 10 MS/s from 50 MHz). Reports underruns (tick with empty FIFO) and late ticks (tick while the previous sample is still unaccepted).

## Interface
- `data_width`, 16, sample width (signed, passed through unmodified)
- `clk_div`, 5, clocks per output sample slot; ≥2
- `fifo_depth`, 16, FIFO entries; power of 2, ≥4
- `clk`  in  1  single system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- `en`  in  1  pacing enable; low holds the tick counter at 0
- `clr_status`  in  1  synchronous clear of `underrun_cnt` and `late_flag`
- `s_axis_tdata`  in  `data_width`  incoming sample
- `s_axis_tvalid`  in  1  incoming sample valid
- `s_axis_tready`  out  1  registered; high when the FIFO is not full
- `m_axis_tdata`  out  `data_width`  paced sample to the filter
- `m_axis_tvalid`  out  1  paced sample valid
- `m_axis_tready`  in  1  filter ready
- `fifo_level`  out  $clog2(`fifo_depth`)+1  current occupancy
- `underrun_cnt`  out  16  saturating count of ticks that found the FIFO empty
- `late_flag`  out  1  sticky; set when a tick occurs while in HOLD

## Operation
- **Input side:** a push occurs when `s_axis_tvalid & s_axis_tready`. Data is written at the tail.
  - `s_axis_tready` is registered as !full of the next-state level.
  - A pop in the same cycle does not make room for a push that cycle.
- **FIFO:** registered storage, no fall-through. A sample pushed at edge k is poppable at edge k+1 at the earliest. Pointers wrap modulo `fifo_depth`.
- **Tick counter `cnt`:**
  - While `en`=1: increments each edge, 0..`clk_div`-1, then wraps to 0.
  - While `en`=0: held at 0.
  - `tick` = `en` & (`cnt`==`clk_div`-1).
- **State machine:**
  - **PACE:** waiting for a tick.
    - tick & !empty → pop the head into `m_axis_tdata`, set `m_axis_tvalid`, go to HOLD.
    - tick & empty → `underrun_cnt`+1 (saturates at 65535), stay in PACE.
  - **HOLD:** `m_axis_tvalid`=1 with data stable.
    - `m_axis_tready`=1 → transfer; `m_axis_tvalid`=0 next edge; go to PACE.
    - tick while in HOLD (including the tick on the accepting edge) → set `late_flag`. No extra pop; that slot is lost. The counter keeps running.
- **`en` deasserted in HOLD:** valid stays asserted until accepted (AXIS no-withdraw rule). After that, no new pop occurs until `en`=1 and a tick.
- **`clr_status`:** clears both status outputs.
  - Clear has priority over a same-cycle increment or set.
  - A same-cycle underrun or late event is dropped.
- **Reset (asserted at any time, including mid-HOLD):** immediately forces:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0
  - `s_axis_tready`=0
  - `fifo_level`=0, pointers=0, `cnt`=0
  - `underrun_cnt`=0, `late_flag`=0
  - state=PACE
  - FIFO contents are discarded.

## Timing
- **After `rst_n` rises:** `s_axis_tready` goes 1 at the first rising edge.
- **Pop latency:** sample registered on the tick edge; `m_axis_tvalid` is high in the cycle after the tick edge.
- **`en` rises with the FIFO non-empty:** the first pop occurs on the `clk_div`-th edge with `en`=1. Then one pop every `clk_div` edges while the filter accepts in the same cycle.
- **Filter `m_axis_tready` held high:** `m_axis_tvalid` is a one-cycle pulse every `clk_div` cycles.
- **`fifo_level`:** updates on the edge of a push or pop. Simultaneous push and pop leaves it unchanged.
- **Full to not full:** pop at edge k → `s_axis_tready`=1 after edge k.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-traffic → all outputs 0 immediately. Release → `s_axis_tready`=1 after one edge; no `m_axis_tvalid` while `en`=0.
- **Impulse, paced:** with `en`=0, push 32767, 0, 0, 0. Then `en`=1 with `m_axis_tready`=1 → four single-cycle valids exactly 5 clocks apart, data 32767, 0, 0, 0 in order. The first valid follows the 5th edge after `en` rose.
- **FIFO full:** push 20 samples continuously with `en`=0 → `fifo_level`=16 and `s_axis_tready`=0 after the 16th accept. Samples 17–20 are not accepted. Then `en`=1 → `s_axis_tready`=1 the cycle after the first pop; output order is 1..16.
- **Underrun:** `en`=1, FIFO empty for 15 cycles → `underrun_cnt`=3, `m_axis_tvalid` never high. Pulse `clr_status` → 0 next edge.
- **Backpressure:** 2 samples queued, `m_axis_tready`=0 for 12 cycles after the first valid:
  - data stays stable and valid stays high;
  - `late_flag`=1 after the next tick;
  - on release exactly one transfer, and the second sample pops only at a later tick;
  - `fifo_level` drops by 1 per pop.
- **Reset mid-HOLD:** drop `rst_n` while `m_axis_tvalid`=1 and `fifo_level`=5 → valid drops without a clock edge, `fifo_level`=0. After release, no stale data is emitted.

Source files
------------

// File: rtl/axis_sample_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axis_sample_pacer                                               |
// | Brief  : AXIS sample FIFO that releases one sample every clk_div clocks  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module axis_sample_pacer #(
  parameter int data_width = 16,
  parameter int clk_div    = 5,
  parameter int fifo_depth = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            clr_status,
  input  logic [data_width-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [data_width-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(fifo_depth):0]     fifo_level,
  output logic [15:0]                     underrun_cnt,
  output logic                            late_flag
);

  localparam int c_ptr_w = $clog2(fifo_depth);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_cnt_w = $clog2(clk_div);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(clk_div - 1);
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(fifo_depth);

  typedef enum logic [0:0] {
    ST_PACE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   w_tick;
  logic [data_width-1:0]  r_mem [fifo_depth];
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_lvl_w-1:0]     r_level;
  logic [c_lvl_w-1:0]     w_level_nxt;
  logic                   r_s_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_underrun;
  logic                   w_late;
  logic [data_width-1:0]  r_out_data;
  logic [15:0]            r_underrun_cnt;
  logic                   r_late_flag;

  assign w_tick   = en && (r_cnt == c_cnt_last);
  assign w_empty  = (r_level == '0);
  assign w_push   = s_axis_tvalid && r_s_ready;
  assign w_level_nxt = r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);

  // Sample-slot counter; held at zero while pacing is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_tdata;
    end
  end

  // Ready is based on the registered level, so a same-cycle pop never frees room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_level   <= w_level_nxt;
      r_s_ready <= (w_level_nxt != c_full_lvl);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PACE;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_out_data <= r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    w_late      = 1'b0;
    case (r_state)
      ST_PACE: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_underrun = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A tick while the previous sample is still pending loses that slot.
        w_late = w_tick;
        if (m_axis_tready) w_state_nxt = ST_PACE;
      end
      default: w_state_nxt = ST_PACE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
      r_late_flag    <= 1'b0;
    end else if (clr_status) begin
      r_underrun_cnt <= '0;
      r_late_flag    <= 1'b0;
    end else begin
      if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
      if (w_late) r_late_flag <= 1'b1;
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = (r_state == ST_HOLD);
  assign m_axis_tdata  = r_out_data;
  assign fifo_level    = r_level;
  assign underrun_cnt  = r_underrun_cnt;
  assign late_flag     = r_late_flag;

endmodule
`default_nettype wire

// File: tb/tb_axis_sample_pacer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_axis_sample_pacer                                            |
// | Brief  : directed + random bench for axis_sample_pacer with slot model   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_axis_sample_pacer;

  localparam int CLK_DIV = 5;
  localparam int DEPTH   = 16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr_status;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;
  logic        late_flag;

  int errors = 0;
  int checks = 0;

  // Reference model: a sample queue plus "edges since en rose" slot timing.
  int q[$];
  int m_data;
  bit m_hold;
  bit m_rdy;
  int m_unc;
  bit m_late;
  int m_en_run;

  axis_sample_pacer #(
    .data_width (16),
    .clk_div    (CLK_DIV),
    .fifo_depth (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .clr_status    (clr_status),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .underrun_cnt  (underrun_cnt),
    .late_flag     (late_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data   = 0;
    m_hold   = 0;
    m_rdy    = 0;
    m_unc    = 0;
    m_late   = 0;
    m_en_run = 0;
  endtask

  task automatic model_edge();
    bit tick, push, pop, und, lt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = en && ((m_en_run % CLK_DIV) == CLK_DIV - 1);
    push = s_axis_tvalid && m_rdy;
    pop  = !m_hold && tick && (q.size() > 0);
    und  = !m_hold && tick && (q.size() == 0);
    lt   = m_hold && tick;
    if (m_hold && m_axis_tready) m_hold = 0;
    if (pop) begin
      m_data = q.pop_front();
      m_hold = 1;
    end
    if (push) q.push_back(int'(s_axis_tdata));
    m_en_run = en ? m_en_run + 1 : 0;
    if (clr_status) begin
      m_unc  = 0;
      m_late = 0;
    end else begin
      if (und && m_unc < 65535) m_unc++;
      if (lt) m_late = 1;
    end
    m_rdy = (q.size() < DEPTH);
  endtask

  task automatic check_all();
    chk("tvalid", m_axis_tvalid, m_hold);
    chk("tdata", m_axis_tdata, m_data);
    chk("s_tready", s_axis_tready, m_rdy);
    chk("level", fifo_level, q.size());
    chk("underrun_cnt", underrun_cnt, m_unc);
    chk("late_flag", late_flag, m_late);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; clr_status = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    model_reset();

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("ready_after_release", s_axis_tready, 1);
    repeat (4) cycle();

    // Impulse, paced
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = (i == 0) ? 16'd32767 : 16'd0;
      cycle();
    end
    s_axis_tvalid = 1'b0;
    chk("impulse_level", fifo_level, 4);
    en = 1'b1; m_axis_tready = 1'b1;
    repeat (4) begin
      cycle();
      chk("impulse_early_valid", m_axis_tvalid, 0);
    end
    cycle();
    chk("impulse_first_valid", m_axis_tvalid, 1);
    chk("impulse_first_data", m_axis_tdata, 32767);
    repeat (20) cycle();

    // FIFO full
    en = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      s_axis_tdata = 16'(i);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    chk("full_level", fifo_level, 16);
    chk("full_tready", s_axis_tready, 0);
    en = 1'b1;
    repeat (90) cycle();

    // Underrun
    en = 1'b0; clr_status = 1'b1;
    cycle();
    clr_status = 1'b0; en = 1'b1;
    repeat (15) cycle();
    chk("underrun_3", underrun_cnt, 3);
    clr_status = 1'b1;
    cycle();
    clr_status = 1'b0;
    chk("underrun_clr", underrun_cnt, 0);

    // Backpressure
    en = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis_tdata = 16'(16'h1234 + i);
      cycle();
    end
    s_axis_tvalid = 1'b0; en = 1'b1;
    repeat (5) cycle();
    chk("bp_valid", m_axis_tvalid, 1);
    chk("bp_level", fifo_level, 1);
    repeat (12) cycle();
    chk("bp_data_stable", m_axis_tdata, 16'h1234);
    chk("bp_late", late_flag, 1);
    m_axis_tready = 1'b1;
    repeat (15) cycle();

    // Reset mid-HOLD
    en = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_axis_tdata = 16'(16'h0A00 + i);
      cycle();
    end
    s_axis_tvalid = 1'b0; en = 1'b1;
    repeat (5) cycle();
    chk("hold_valid", m_axis_tvalid, 1);
    chk("hold_level", fifo_level, 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", m_axis_tvalid, 0);
    chk("async_level", fifo_level, 0);
    chk("async_tdata", m_axis_tdata, 0);
    chk("async_tready", s_axis_tready, 0);
    repeat (2) cycle();
    rst_n = 1'b1; m_axis_tready = 1'b1;
    repeat (20) cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = 16'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      en            = ($urandom_range(0, 15) != 0);
      clr_status    = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
